// File: rtl/seg_scan_ctrl_if.sv
// Display-side bus of the eight-digit seven-segment scanner: value load
// handshake in, multiplexed segment/anode drive and frame markers out.
interface seg_scan_ctrl_if;
    logic [15:0] NumberA;
    logic [15:0] NumberB;
    logic        LZB_En;
    logic        Load;
    logic        Ack;
    logic        FrameStart;
    logic [6:0]  out7;
    logic [7:0]  en_out;

    modport slave (
        input  NumberA, NumberB, LZB_En, Load,
        output Ack, FrameStart, out7, en_out
    );

    modport master (
        output NumberA, NumberB, LZB_En, Load,
        input  Ack, FrameStart, out7, en_out
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: blank/show slots per digit,
// leading-zero blanking, and tear-free value updates applied at frame start.
module seg_scan_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic           Clk,
    input  logic           Reset,
    seg_scan_ctrl_if.slave bus
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    typedef struct packed {
        logic [15:0] num_a;
        logic [15:0] num_b;
        logic        lzb;
    } disp_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic          run;
    logic          frame_edge;

    disp_t         active, pending;
    logic          pend_vld;

    logic [31:0]   digits;
    logic [7:0]    blank;
    logic [6:0]    seg_nxt;
    logic [7:0]    en_nxt;

    logic [6:0]    out7_q;
    logic [7:0]    en_q;
    logic          ack_q;
    logic          fs_q;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Nibble i of this word belongs to anode i.
    assign digits = {active.num_a, active.num_b};

    // Digit k of a group blanks when it and every more-significant digit is zero.
    for (genvar g = 0; g < 8; g++) begin : g_lzb
        localparam int K    = g % 4;
        localparam int BASE = g - K;
        if (K == 0) begin : g_lsd
            assign blank[g] = 1'b0;
        end else begin : g_upper
            assign blank[g] = active.lzb && ~|digits[4*BASE+15 : 4*(BASE+K)];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // First edge out of reset enters digit 0's blank slot as a frame boundary.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        frame_edge = 1'b0;
        if (!run) begin
            state_nxt  = BLANK;
            cnt_nxt    = '0;
            idx_nxt    = '0;
            frame_edge = 1'b1;
        end else begin
            case (state)
                BLANK: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == BLANK_LAST) state_nxt = SHOW;
                end
                SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        cnt_nxt    = '0;
                        idx_nxt    = idx + 1'b1;
                        state_nxt  = BLANK;
                        frame_edge = (idx == 3'd7);
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = BLANK;
            endcase
        end

        en_nxt  = 8'hFF;
        seg_nxt = 7'h7F;
        if (state_nxt == SHOW) begin
            en_nxt  = ~(8'h01 << idx_nxt);
            seg_nxt = blank[idx_nxt] ? 7'h7F : hex7(digits[{idx_nxt, 2'b00} +: 4]);
        end
    end

    // Apply the old pending value before capturing a coincident Load.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run      <= 1'b0;
            active   <= '0;
            pending  <= '0;
            pend_vld <= 1'b0;
            out7_q   <= 7'h7F;
            en_q     <= 8'hFF;
            ack_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            run    <= 1'b1;
            fs_q   <= frame_edge;
            ack_q  <= frame_edge && pend_vld;
            out7_q <= seg_nxt;
            en_q   <= en_nxt;
            if (frame_edge && pend_vld) begin
                active   <= pending;
                pend_vld <= 1'b0;
            end
            if (bus.Load) begin
                pending  <= '{num_a: bus.NumberA, num_b: bus.NumberB, lzb: bus.LZB_En};
                pend_vld <= 1'b1;
            end
        end
    end

    assign bus.out7       = out7_q;
    assign bus.en_out     = en_q;
    assign bus.Ack        = ack_q;
    assign bus.FrameStart = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a cycle-time display model checked on
// every clock, plus literal checks of key digits and handshake events.
module tb_seg_scan_ctrl;

    localparam int TICK  = 8;
    localparam int BLK   = 2;
    localparam int FRAME = 8 * TICK;

    logic Clk;
    logic Reset;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.TICK_DIV(TICK), .BLANK_CYC(BLK)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int tests = 0;
    int fails = 0;

    // Model state: t counts cycles since the first edge after reset release.
    int          t      = 0;
    bit          run_m  = 0;
    bit          pv     = 0;
    logic [15:0] act_a  = '0, act_b = '0, pend_a = '0, pend_b = '0;
    logic        act_lz = 1'b0, pend_lz = 1'b0;
    int          ack_seen = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [7:0] exp_en(input int tt);
        int slot;
        logic [7:0] m;
        slot = (tt / TICK) % 8;
        if (tt % TICK < BLK) return 8'hFF;
        m = 8'h01 << slot;
        return ~m;
    endfunction

    function automatic logic [6:0] exp_seg(input int tt, input logic [15:0] a,
                                           input logic [15:0] b, input logic lz);
        int slot, k;
        logic [15:0] grp, upper;
        slot = (tt / TICK) % 8;
        if (tt % TICK < BLK) return 7'h7F;
        grp   = (slot < 4) ? b : a;
        k     = slot % 4;
        upper = grp >> (4 * k);
        if (lz && k > 0 && upper == 16'h0) return 7'h7F;
        return seg_of(upper[3:0]);
    endfunction

    always @(posedge Clk) begin
        logic        ld, lz_in, bnd, ack_e;
        logic [15:0] na, nb;
        ld = bus.Load; na = bus.NumberA; nb = bus.NumberB; lz_in = bus.LZB_En;
        #1;
        if (bus.Ack === 1'b1) ack_seen++;
        if (!Reset) begin
            run_m = 0; pv = 0;
            act_a = '0; act_b = '0; act_lz = 1'b0;
            chk("m_rst_out7", bus.out7, 7'h7F);
            chk("m_rst_en", bus.en_out, 8'hFF);
            chk("m_rst_ack", bus.Ack, 1'b0);
            chk("m_rst_fs", bus.FrameStart, 1'b0);
        end else begin
            if (!run_m) begin
                run_m = 1; t = 0;
            end else begin
                t++;
            end
            bnd   = (t % FRAME == 0);
            ack_e = bnd && pv;
            if (ack_e) begin
                act_a = pend_a; act_b = pend_b; act_lz = pend_lz; pv = 0;
            end
            if (ld) begin
                pend_a = na; pend_b = nb; pend_lz = lz_in; pv = 1;
            end
            chk("m_out7", bus.out7, exp_seg(t, act_a, act_b, act_lz));
            chk("m_en", bus.en_out, exp_en(t));
            chk("m_fs", bus.FrameStart, bnd);
            chk("m_ack", bus.Ack, ack_e);
        end
    end

    task automatic goto(input int target);
        int n;
        n = 0;
        while (!(run_m && t == target) && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 2000) begin
            tests++; fails++;
            $display("FAIL timeout: never reached t=%0d, stuck at t=%0d", target, t);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b, input logic lz);
        bus.NumberA = a; bus.NumberB = b; bus.LZB_En = lz; bus.Load = 1'b1;
        @(negedge Clk);
        bus.Load = 1'b0;
    endtask

    initial begin
        int acks0;
        bus.NumberA = '0; bus.NumberB = '0; bus.LZB_En = 1'b0; bus.Load = 1'b0;
        Reset = 1'b1;
        #1 Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_out7", bus.out7, 7'h7F);
        chk("rst_en", bus.en_out, 8'hFF);
        chk("rst_ack", bus.Ack, 1'b0);
        Reset = 1'b1;

        // Scenario 1: free-running after reset, all zeros shown.
        goto(0);  chk("first_fs", bus.FrameStart, 1'b1); chk("first_en", bus.en_out, 8'hFF);
        goto(1);  chk("blank1_en", bus.en_out, 8'hFF);
        goto(2);  chk("d0_en", bus.en_out, 8'hFE); chk("d0_zero", bus.out7, 7'b1000000);
        goto(8);  chk("d1_blank_en", bus.en_out, 8'hFF);
        goto(10); chk("d1_en", bus.en_out, 8'hFD);

        // Scenario 2: load mid-frame, applied at next frame start.
        goto(20); load(16'h1234, 16'hABCF, 1'b0);
        goto(30); chk("no_tear", bus.out7, 7'b1000000);
        goto(64); chk("s2_ack", bus.Ack, 1'b1); chk("s2_fs", bus.FrameStart, 1'b1);
        goto(66); chk("s2_d0_F", bus.out7, 7'b0001110);
        goto(74); chk("s2_d1_C", bus.out7, 7'b1000110);
        goto(122); chk("s2_d7_1", bus.out7, 7'b1111001);

        // Scenario 3: leading-zero blanking.
        goto(130); load(16'h0000, 16'h0005, 1'b1);
        goto(194); chk("s3_d0_5", bus.out7, 7'b0010010);
        goto(202); chk("s3_d1_blank", bus.out7, 7'h7F); chk("s3_d1_en", bus.en_out, 8'hFD);
        goto(226); chk("s3_d4_0", bus.out7, 7'b1000000);
        goto(234); chk("s3_d5_blank", bus.out7, 7'h7F); chk("s3_d5_en", bus.en_out, 8'hDF);

        // Scenario 4: two loads in one frame, one ack, latest wins.
        goto(256); acks0 = ack_seen;
        goto(260); load(16'h1111, 16'h1111, 1'b0);
        goto(270); load(16'h2222, 16'h2222, 1'b0);
        goto(322); chk("s4_d0_2", bus.out7, 7'b0100100);
        goto(330); chk("s4_one_ack", 16'(ack_seen - acks0), 16'd1);

        // Scenario 5: load coincides with the applying frame edge.
        load(16'h3333, 16'h3333, 1'b0);
        goto(383); load(16'h4444, 16'h4444, 1'b0);
        chk("s5_ack_3", bus.Ack, 1'b1);
        goto(386); chk("s5_d0_3", bus.out7, 7'b0110000);
        goto(448); chk("s5_ack_4", bus.Ack, 1'b1);
        goto(450); chk("s5_d0_4", bus.out7, 7'b0011001);

        // Scenario 6: reset during a SHOW slot with a value pending.
        goto(460); load(16'h5555, 16'h5555, 1'b0);
        goto(470);
        #2 Reset = 1'b0;
        #1;
        chk("async_out7", bus.out7, 7'h7F);
        chk("async_en", bus.en_out, 8'hFF);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        acks0 = ack_seen;
        goto(2);  chk("s6_d0_zero", bus.out7, 7'b1000000);
        goto(64); chk("s6_no_ack", bus.Ack, 1'b0); chk("s6_fs", bus.FrameStart, 1'b1);
        goto(66); chk("s6_discarded", bus.out7, 7'b1000000);
        chk("s6_ack_cnt", 16'(ack_seen - acks0), 16'd0);

        @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
